// File: rtl/card_authorizer_pkg.sv
// Shared definitions for the card authorizer: EEPROM command codes, FSM state
// encodings and the ID geometry.
package card_authorizer_pkg;

  localparam int ID_BYTES = 16;

  typedef enum logic [2:0] {
    CMD_WREN  = 3'b000,
    CMD_WRDI  = 3'b001,
    CMD_RDSR  = 3'b010,
    CMD_WRSR  = 3'b011,
    CMD_READ  = 3'b100,
    CMD_WRITE = 3'b101
  } eeprom_cmd_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_DECIDE = 2'd3;

  // Byte 0 is the most significant byte of the ID; ~idx*8 is (15-idx)*8.
  function automatic logic [7:0] id_byte(input logic [127:0] id, input logic [3:0] idx);
    return id[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/card_authorizer_if.sv
// EEPROM command port: the authorizer is the master, the EEPROM controller the slave.
interface card_authorizer_if;
  import card_authorizer_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  eeprom_cmd_e cmd_type;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [7:0]  cmd_rdata;
  logic        cmd_done;
  logic        cmd_error;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata,
    input  cmd_ready, cmd_rdata, cmd_done, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata,
    output cmd_ready, cmd_rdata, cmd_done, cmd_error
  );
endinterface

// File: rtl/card_authorizer.sv
// Checks an authenticated 128-bit card ID against the authorized-ID slots held
// in EEPROM, byte by byte, and reports grant or deny to door control.
module card_authorizer
  import card_authorizer_pkg::*;
#(
  parameter int         NUM_SLOTS      = 4,
  parameter logic [6:0] BASE_ADDR      = 7'h10,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [127:0]        card_id,
  output logic                result_valid,
  output logic                granted,
  output logic                denied,
  output logic                fault,
  output logic [2:0]          match_slot,
  card_authorizer_if.master   eeprom
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t               state;
  logic [127:0]         id_q;
  logic [2:0]           slot_q;
  logic [3:0]           byte_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 cmd_valid_q;

  logic last_slot;
  logic last_byte;
  logic byte_match;
  logic timed_out;

  assign last_slot  = (slot_q == 3'(NUM_SLOTS - 1));
  assign last_byte  = (byte_q == 4'(ID_BYTES - 1));
  assign byte_match = (eeprom.cmd_rdata == id_byte(id_q, byte_q));
  assign timed_out  = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  assign eeprom.cmd_valid = cmd_valid_q;
  assign eeprom.cmd_type  = CMD_READ;
  assign eeprom.cmd_wdata = 8'h00;
  assign eeprom.cmd_addr  = BASE_ADDR + {slot_q, 4'b0000} + {3'b000, byte_q};

  assign result_valid = (state == ST_DECIDE);

  // NOTE: every register below uses <= so all of them update from the same
  // pre-edge values; a blocking assignment would leak new values into later lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      cmd_valid_q <= 1'b0;
      slot_q      <= '0;
      byte_q      <= '0;
      timer_q     <= '0;
      granted     <= 1'b0;
      denied      <= 1'b0;
      fault       <= 1'b0;
      match_slot  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            // NOTE: id_q is pure data, loaded before every use, so it needs no reset.
            id_q       <= card_id;
            req_ready  <= 1'b0;
            granted    <= 1'b0;
            denied     <= 1'b0;
            fault      <= 1'b0;
            match_slot <= '0;
            slot_q     <= '0;
            byte_q     <= '0;
            state      <= ST_ISSUE;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_ISSUE: begin
          // First ISSUE cycle after acceptance screens the erased pattern.
          if (!cmd_valid_q) begin
            if (&id_q) begin
              denied <= 1'b1;
              state  <= ST_DECIDE;
            end else begin
              cmd_valid_q <= 1'b1;
            end
          end else if (eeprom.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            timer_q     <= '0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (eeprom.cmd_done) begin
            if (eeprom.cmd_error) begin
              denied <= 1'b1;
              fault  <= 1'b1;
              state  <= ST_DECIDE;
            end else if (byte_match) begin
              if (last_byte) begin
                granted    <= 1'b1;
                match_slot <= slot_q;
                state      <= ST_DECIDE;
              end else begin
                byte_q      <= byte_q + 4'd1;
                cmd_valid_q <= 1'b1;
                state       <= ST_ISSUE;
              end
            end else begin
              // Early exit on the first differing byte; move on to the next slot.
              byte_q <= '0;
              slot_q <= slot_q + 3'd1;
              if (last_slot) begin
                denied <= 1'b1;
                state  <= ST_DECIDE;
              end else begin
                cmd_valid_q <= 1'b1;
                state       <= ST_ISSUE;
              end
            end
          end else if (timed_out) begin
            denied <= 1'b1;
            fault  <= 1'b1;
            state  <= ST_DECIDE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        ST_DECIDE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
